// File: rtl/pbs_move_resolve_if.sv
// Handshake and data bundle for the move resolver.
// The driver side (master) issues requests and seeds the LFSR.
// The resolver side (slave) returns status and results.
interface pbs_move_resolve_if;
  logic       start;
  logic       attacker;
  logic [1:0] move;
  logic [3:0] p_hp_in;
  logic [3:0] ai_hp_in;
  logic       seed_ld;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic       hit;
  logic       crit;
  logic [3:0] dmg;
  logic [3:0] new_hp;
  logic       target_ko;

  modport master (
    output start, attacker, move, p_hp_in, ai_hp_in, seed_ld, seed,
    input  busy, done, hit, crit, dmg, new_hp, target_ko
  );

  modport slave (
    input  start, attacker, move, p_hp_in, ai_hp_in, seed_ld, seed,
    output busy, done, hit, crit, dmg, new_hp, target_ko
  );
endinterface

// File: rtl/pbs_move_resolve.sv
// Turn-based move resolver: IDLE -> LOOKUP -> ROLL -> APPLY -> DONE.
// It latches the request and looks up the move table.
// It rolls against the LFSR and then applies saturating damage to the target HP.
// Optional feature macro: PBS_CRIT_EN (critical hits double the damage, saturating at 15).
module pbs_move_resolve (
  input  logic              clk,
  input  logic              reset_n,
  pbs_move_resolve_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_ROLL, S_APPLY, S_DONE
  } state_t;

  state_t     state_q;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] move_q;
  logic [3:0] tgt_q;
  logic [3:0] base_q, accu_q;
  logic       roll_hit_q;
  logic       hit_q, done_q, ko_q;
  logic [3:0] dmg_q, new_hp_q;
  logic [3:0] tbl_dmg, tbl_accu;
  logic [4:0] eff_w;
  logic [3:0] eff, new_hp_d;
`ifdef PBS_CRIT_EN
  logic       roll_crit_q, crit_q;
`endif

  // Fixed move table: (base damage, accuracy threshold)
  always_comb begin
    tbl_dmg  = 4'd2;
    tbl_accu = 4'd15;
    case (move_q)
      2'd0: begin tbl_dmg = 4'd2; tbl_accu = 4'd15; end
      2'd1: begin tbl_dmg = 4'd4; tbl_accu = 4'd11; end
      2'd2: begin tbl_dmg = 4'd6; tbl_accu = 4'd7;  end
      2'd3: begin tbl_dmg = 4'd9; tbl_accu = 4'd3;  end
      default: ;
    endcase
  end

  // Effective damage and the saturating HP subtraction used in APPLY
  always_comb begin
    eff_w = roll_hit_q ? {1'b0, base_q} : 5'd0;
`ifdef PBS_CRIT_EN
    if (roll_crit_q) eff_w = {base_q, 1'b0};
`endif
    eff      = (eff_w > 5'd15) ? 4'd15 : eff_w[3:0];
    new_hp_d = (tgt_q > eff) ? (tgt_q - eff) : 4'd0;
  end

  // LFSR next value: a seed load wins, otherwise shift once in APPLY; zero seeds become 1
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.seed_ld)
      lfsr_d = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
    else if (state_q == S_APPLY)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end

  // Resolver FSM with registered results and a done pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      move_q     <= 2'd0;
      tgt_q      <= 4'd0;
      base_q     <= 4'd0;
      accu_q     <= 4'd0;
      roll_hit_q <= 1'b0;
      hit_q      <= 1'b0;
      dmg_q      <= 4'd0;
      new_hp_q   <= 4'd0;
      ko_q       <= 1'b0;
      done_q     <= 1'b0;
`ifdef PBS_CRIT_EN
      roll_crit_q <= 1'b0;
      crit_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            move_q  <= bus.move;
            tgt_q   <= bus.attacker ? bus.p_hp_in : bus.ai_hp_in;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          base_q  <= tbl_dmg;
          accu_q  <= tbl_accu;
          state_q <= S_ROLL;
        end
        S_ROLL: begin
          roll_hit_q <= (lfsr_q[3:0] <= accu_q);
`ifdef PBS_CRIT_EN
          roll_crit_q <= (lfsr_q[3:0] <= accu_q) && (lfsr_q[7:5] == 3'b111);
`endif
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          hit_q    <= roll_hit_q;
          dmg_q    <= eff;
          new_hp_q <= new_hp_d;
          ko_q     <= (new_hp_d == 4'd0);
`ifdef PBS_CRIT_EN
          crit_q   <= roll_crit_q;
`endif
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.dmg       = dmg_q;
  assign bus.new_hp    = new_hp_q;
  assign bus.target_ko = ko_q;
`ifdef PBS_CRIT_EN
  assign bus.crit      = crit_q;
`else
  assign bus.crit      = 1'b0;
`endif

endmodule

// File: tb/tb_pbs_move_resolve.sv
// Directed and randomized checks of pbs_move_resolve against a behavioural model.
module tb_pbs_move_resolve;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pbs_move_resolve_if bus();
  pbs_move_resolve dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  localparam int DMG [4] = '{2, 4, 6, 9};
  localparam int ACC [4] = '{15, 11, 7, 3};
`ifdef PBS_CRIT_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int m_lfsr;
  int p_hit, p_crit, p_dmg, p_hp, p_ko;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int lstep(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l * 2) % 256) + fb;
  endfunction

  function automatic int seedfix(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  task automatic scramble();
    bus.attacker = 1'($urandom);
    bus.move     = 2'($urandom);
    bus.p_hp_in  = 4'($urandom);
    bus.ai_hp_in = 4'($urandom);
    bus.start    = 1'($urandom);
  endtask

  task automatic run(input bit ld, input int sv, input bit att, input int mv,
                     input int php, input int ahp, input bit mid_ld, input int msv);
    int hp, roll, eff, nhp;
    bit hit, crit;
    if (ld) begin
      bus.seed_ld = 1'b1; bus.seed = 8'(sv);
      tick();
      bus.seed_ld = 1'b0;
      m_lfsr = seedfix(sv);
    end
    hp   = att ? php : ahp;
    roll = m_lfsr % 16;
    hit  = (roll <= ACC[mv]);
    crit = CRIT && hit && ((m_lfsr / 32) == 7);
    eff  = hit ? DMG[mv] * (crit ? 2 : 1) : 0;
    if (eff > 15) eff = 15;
    nhp  = (hp > eff) ? hp - eff : 0;

    bus.start = 1'b1; bus.attacker = att; bus.move = 2'(mv);
    bus.p_hp_in = 4'(php); bus.ai_hp_in = 4'(ahp);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("busy_run", 8'(bus.busy), 8'd1);
      chk("done_early", 8'(bus.done), 8'd0);
      chk("hold_hp", 8'(bus.new_hp), 8'(p_hp));
      scramble();
      if (i == 2 && mid_ld) begin bus.seed_ld = 1'b1; bus.seed = 8'(msv); end
      tick();
    end
    bus.seed_ld = 1'b0;
    bus.start   = 1'b0;
    m_lfsr = mid_ld ? seedfix(msv) : lstep(m_lfsr);
    chk("done", 8'(bus.done), 8'd1);
    chk("busy_done", 8'(bus.busy), 8'd1);
    chk("hit", 8'(bus.hit), 8'(hit));
    chk("crit", 8'(bus.crit), 8'(crit));
    chk("dmg", 8'(bus.dmg), 8'(eff));
    chk("new_hp", 8'(bus.new_hp), 8'(nhp));
    chk("ko", 8'(bus.target_ko), 8'(nhp == 0));
    p_hit = hit; p_crit = crit; p_dmg = eff; p_hp = nhp; p_ko = (nhp == 0);
    tick();
    chk("done_pulse", 8'(bus.done), 8'd0);
    chk("busy_idle", 8'(bus.busy), 8'd0);
    chk("hold_after", 8'(bus.new_hp), 8'(p_hp));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 8'(bus.busy), 8'd0);
    chk({tag, "_done"}, 8'(bus.done), 8'd0);
    chk({tag, "_hit"}, 8'(bus.hit), 8'd0);
    chk({tag, "_crit"}, 8'(bus.crit), 8'd0);
    chk({tag, "_dmg"}, 8'(bus.dmg), 8'd0);
    chk({tag, "_hp"}, 8'(bus.new_hp), 8'd0);
    chk({tag, "_ko"}, 8'(bus.target_ko), 8'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.attacker = 1'b0; bus.move = 2'd0;
    bus.p_hp_in = 4'd0; bus.ai_hp_in = 4'd0; bus.seed_ld = 1'b0; bus.seed = 8'd0;
    tick(); tick();
    chk_zero("reset");
    reset_n = 1'b1;
    m_lfsr = 8'hA5;
    p_hit = 0; p_crit = 0; p_dmg = 0; p_hp = 0; p_ko = 0;

    run(1, 8'h0C, 0, 1, 3, 10, 0, 0);   // miss
    run(1, 8'h0B, 0, 1, 3, 10, 0, 0);   // hit, 4 damage
    run(0, 0,     0, 1, 3, 10, 0, 0);   // uses the advanced LFSR
    run(1, 8'h02, 1, 3, 5, 12, 0, 0);   // KO on the player
    run(1, 8'hE0, 0, 2, 1, 15, 0, 0);   // crit candidate
    run(1, 8'hE0, 0, 3, 1, 15, 0, 0);   // crit saturating at 15
    run(1, 8'h00, 0, 0, 1, 9,  0, 0);   // zero seed loads as 1
    run(1, 8'h01, 1, 0, 0, 9,  0, 0);   // target already at 0
    run(1, 8'h3C, 0, 2, 1, 8,  1, 8'h00); // seed load beats APPLY shift
    run(0, 0,     0, 1, 1, 8,  0, 0);

    // Reset during ROLL aborts without a done pulse
    bus.start = 1'b1; bus.move = 2'd2; bus.ai_hp_in = 4'd9; bus.attacker = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_nodone", 8'(bus.done), 8'd0);
    end
    m_lfsr = 8'hA5;
    p_hit = 0; p_crit = 0; p_dmg = 0; p_hp = 0; p_ko = 0;
    run(0, 0, 0, 3, 2, 10, 0, 0);       // roll 5 from reset LFSR misses move 3

    for (int k = 0; k < 25; k++) begin
      bit ld;
      ld = ($urandom_range(0, 3) == 0);
      run(ld, int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          ($urandom_range(0, 4) == 0), int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
